// File: rtl/vga_space_ctrl.sv
// Mode sequencer and pipeline wrapper around the RGB->YPbPr converter.
// Mode changes apply at a VS leading edge, followed by MUTE_FRAMES black frames.
//
// state   | meaning
// IDLE    | accepting requests, cfg_ready high
// WAIT_VS | request latched, waiting for a VS leading edge to apply it
// MUTE    | new mode applied, converter input forced black until mute_cnt expires
module vga_space_ctrl #(
  parameter int PIPE_LAT    = 0,
  parameter int MUTE_FRAMES = 2
) (
  input  logic       clk_vid,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       cfg_valid,
  input  logic       cfg_en,
  input  logic       cfg_full,
  output logic       cfg_ready,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       de_in,
  output logic [5:0] pix_r,
  output logic [5:0] pix_g,
  output logic [5:0] pix_b,
  output logic       ypbpr_en,
  output logic       ypbpr_full,
  input  logic [5:0] cvt_r,
  input  logic [5:0] cvt_g,
  input  logic [5:0] cvt_b,
  output logic [5:0] vga_r,
  output logic [5:0] vga_g,
  output logic [5:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de,
  output logic       muted
);

  localparam int         NSTG   = PIPE_LAT + 2;
  localparam logic [3:0] MUTE_N = 4'(MUTE_FRAMES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VS, ST_MUTE} state_t;

  state_t                 state_q, state_d;
  logic                   vs_prev_q, vs_prev_d;
  logic                   en_q, en_d, full_q, full_d;
  logic                   pend_en_q, pend_en_d, pend_full_q, pend_full_d;
  logic [3:0]             mute_cnt_q, mute_cnt_d;
  logic                   muted_q, muted_d;
  logic [17:0]            pix_q, pix_d;
  logic [17:0]            vga_q, vga_d;
  logic [NSTG-1:0][2:0]   sync_q, sync_d;
  logic                   vs_rise;

  always_comb begin
    state_d     = state_q;
    vs_prev_d   = vs_prev_q;
    en_d        = en_q;
    full_d      = full_q;
    pend_en_d   = pend_en_q;
    pend_full_d = pend_full_q;
    mute_cnt_d  = mute_cnt_q;
    pix_d       = pix_q;
    vga_d       = vga_q;
    sync_d      = sync_q;

    vs_rise = ce_pix & vs_in & ~vs_prev_q;
    if (ce_pix) vs_prev_d = vs_in;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && ({cfg_en, cfg_full} != {en_q, full_q})) begin
          pend_en_d   = cfg_en;
          pend_full_d = cfg_full;
          state_d     = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (vs_rise) begin
          en_d       = pend_en_q;
          full_d     = pend_full_q;
          mute_cnt_d = MUTE_N;
          state_d    = (MUTE_N == 4'd0) ? ST_IDLE : ST_MUTE;
        end
      end
      ST_MUTE: begin
        if (vs_rise) begin
          mute_cnt_d = mute_cnt_q - 4'd1;
          if (mute_cnt_q <= 4'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Black is decided from the next state so the apply sample is already black
    // and the sample at the final VS edge is already live.
    muted_d = (state_d == ST_MUTE);

    if (ce_pix) begin
      pix_d  = muted_d ? 18'd0 : {r_in, g_in, b_in};
      vga_d  = {cvt_r, cvt_g, cvt_b};
      sync_d = {sync_q[NSTG-2:0], {hs_in, vs_in, de_in}};
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vs_prev_q   <= 1'b1;
      en_q        <= 1'b0;
      full_q      <= 1'b0;
      pend_en_q   <= 1'b0;
      pend_full_q <= 1'b0;
      mute_cnt_q  <= 4'd0;
      muted_q     <= 1'b0;
      pix_q       <= 18'd0;
      vga_q       <= 18'd0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      vs_prev_q   <= vs_prev_d;
      en_q        <= en_d;
      full_q      <= full_d;
      pend_en_q   <= pend_en_d;
      pend_full_q <= pend_full_d;
      mute_cnt_q  <= mute_cnt_d;
      muted_q     <= muted_d;
      pix_q       <= pix_d;
      vga_q       <= vga_d;
      sync_q      <= sync_d;
    end
  end

  assign cfg_ready               = (state_q == ST_IDLE);
  assign ypbpr_en                = en_q;
  assign ypbpr_full              = full_q;
  assign muted                   = muted_q;
  assign {pix_r, pix_g, pix_b}   = pix_q;
  assign {vga_r, vga_g, vga_b}   = vga_q;
  assign {vga_hs, vga_vs, vga_de} = sync_q[NSTG-1];

endmodule
